// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle instruction sequencer.
// Walks each instruction through FETCH, DECODE, EXECUTE, optional MEMORY and
// WRITEBACK. It owns the program counter, the instruction register and the
// retired-instruction counter. Fetch and data-memory handshakes are acks that
// may arrive with zero or more wait cycles.
module cpu_sequencer (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] imem_addr,
  output logic        imem_req,
  input  logic [15:0] imem_rdata,
  input  logic        imem_ack,
  output logic [2:0]  state,
  output logic [15:0] instr,
  output logic [3:0]  op_code,
  input  logic        jump,
  input  logic        beq,
  input  logic        bne,
  input  logic        reg_write,
  input  logic [1:0]  mem_op,
  input  logic        alu_zero,
  output logic        mem_req,
  input  logic        dmem_ack,
  output logic        reg_write_en,
  output logic [15:0] pc,
  output logic [15:0] retired
);

  localparam logic [2:0] S_FETCH     = 3'b000;
  localparam logic [2:0] S_DECODE    = 3'b001;
  localparam logic [2:0] S_EXECUTE   = 3'b010;
  localparam logic [2:0] S_MEMORY    = 3'b011;
  localparam logic [2:0] S_WRITEBACK = 3'b100;

  localparam logic [1:0] MEM_LOAD  = 2'b01;
  localparam logic [1:0] MEM_STORE = 2'b10;

  // Sign-extend the 4-bit branch offset to the pc width.
  function automatic logic [15:0] sext4(input logic [3:0] v);
    return {{12{v[3]}}, v};
  endfunction

  logic [2:0]  state_r;
  logic [2:0]  state_next_s;
  logic [15:0] pc_r;
  logic [15:0] pc_next_s;
  logic [15:0] instr_r;
  logic [15:0] retired_r;
  logic [1:0]  mem_op_r;
  logic        instr_load_s;
  logic        mem_op_load_s;
  logic        retire_s;
  logic        branch_taken_s;
  logic        imem_req_s;
  logic        mem_req_s;
  logic        reg_write_en_s;

  // Phase register; reset forces FETCH regardless of any pending handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next phase, next pc and the load/retire enables for the datapath registers.
  always_comb begin
    state_next_s   = state_r;
    pc_next_s      = pc_r;
    instr_load_s   = 1'b0;
    mem_op_load_s  = 1'b0;
    branch_taken_s = (beq & alu_zero) | (bne & ~alu_zero);
    case (state_r)
      S_FETCH: begin
        if (imem_ack) begin
          state_next_s = S_DECODE;
          instr_load_s = 1'b1;
        end else begin
          state_next_s = S_FETCH;
        end
      end
      S_DECODE: begin
        state_next_s = S_EXECUTE;
      end
      S_EXECUTE: begin
        if (jump) begin
          pc_next_s    = {pc_r[15:12], instr_r[11:0]};
          state_next_s = S_FETCH;
        end else if (branch_taken_s) begin
          pc_next_s    = pc_r + 16'd1 + sext4(instr_r[3:0]);
          state_next_s = S_FETCH;
        end else if (beq | bne) begin
          pc_next_s    = pc_r + 16'd1;
          state_next_s = S_FETCH;
        end else if ((mem_op == MEM_LOAD) || (mem_op == MEM_STORE)) begin
          // Remember the access kind so MEMORY does not depend on the decoder
          // holding its outputs for the whole wait.
          mem_op_load_s = 1'b1;
          state_next_s  = S_MEMORY;
        end else begin
          state_next_s = S_WRITEBACK;
        end
      end
      S_MEMORY: begin
        if (dmem_ack) begin
          if (mem_op_r == MEM_LOAD) begin
            state_next_s = S_WRITEBACK;
          end else begin
            pc_next_s    = pc_r + 16'd1;
            state_next_s = S_FETCH;
          end
        end else begin
          state_next_s = S_MEMORY;
        end
      end
      S_WRITEBACK: begin
        pc_next_s    = pc_r + 16'd1;
        state_next_s = S_FETCH;
      end
      default: begin
        // Unused encodings recover to FETCH without touching architectural state.
        state_next_s = S_FETCH;
      end
    endcase
    retire_s = (state_next_s == S_FETCH) &&
               ((state_r == S_EXECUTE) || (state_r == S_MEMORY) ||
                (state_r == S_WRITEBACK));
  end

  // Request strobes decoded from the current phase only.
  always_comb begin
    imem_req_s     = (state_r == S_FETCH);
    mem_req_s      = (state_r == S_MEMORY);
    if (state_r == S_WRITEBACK) begin
      reg_write_en_s = reg_write;
    end else begin
      reg_write_en_s = 1'b0;
    end
  end

  // Architectural registers: pc, instruction register, retired count, latched mem op.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r      <= 16'h0000;
      instr_r   <= 16'h0000;
      retired_r <= 16'h0000;
      mem_op_r  <= 2'b00;
    end else begin
      pc_r <= pc_next_s;
      if (instr_load_s) begin
        instr_r <= imem_rdata;
      end
      if (mem_op_load_s) begin
        mem_op_r <= mem_op;
      end
      if (retire_s) begin
        retired_r <= retired_r + 16'd1;
      end
    end
  end

  assign state        = state_r;
  assign pc           = pc_r;
  assign imem_addr    = pc_r;
  assign instr        = instr_r;
  assign op_code      = instr_r[15:12];
  assign retired      = retired_r;
  assign imem_req     = imem_req_s;
  assign mem_req      = mem_req_s;
  assign reg_write_en = reg_write_en_s;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: a table of instructions executed back to
// back with hand-computed pc results, plus hand-written reset corner cases.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] imem_addr;
  logic        imem_req;
  logic [15:0] imem_rdata;
  logic        imem_ack;
  logic [2:0]  state;
  logic [15:0] instr;
  logic [3:0]  op_code;
  logic        jump, beq, bne, reg_write, alu_zero;
  logic [1:0]  mem_op;
  logic        mem_req;
  logic        dmem_ack;
  logic        reg_write_en;
  logic [15:0] pc;
  logic [15:0] retired;

  cpu_sequencer dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack), .state(state), .instr(instr),
    .op_code(op_code), .jump(jump), .beq(beq), .bne(bne), .reg_write(reg_write),
    .mem_op(mem_op), .alu_zero(alu_zero), .mem_req(mem_req), .dmem_ack(dmem_ack),
    .reg_write_en(reg_write_en), .pc(pc), .retired(retired)
  );

  always #5 clk = ~clk;

  localparam int P_WB = 0, P_LD = 1, P_ST = 2, P_BR = 3;
  localparam bit Y = 1'b1, N = 1'b0;

  typedef struct {
    logic [15:0] rdata;
    int          ack_wait;
    bit          jump, beq, bne, reg_write;
    logic [1:0]  mem_op;
    bit          alu_zero;
    int          dmem_wait;
    int          path;
    logic [15:0] exp_pc;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_pc  = 16'h0000;
  logic [15:0] exp_ret = 16'h0000;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic clear_ctrl();
    jump = 1'b0; beq = 1'b0; bne = 1'b0; reg_write = 1'b0;
    mem_op = 2'b00; alu_zero = 1'b0;
  endtask

  // Runs one instruction starting at a negedge with the DUT in FETCH.
  task automatic run_vec(input int k, input vec_t v);
    int mem_cnt;
    int rwe_seen;
    mem_cnt = 0;
    rwe_seen = 0;
    chk($sformatf("fetch_state[%0d]", k), {13'd0, state}, 16'h0000);
    chk($sformatf("imem_req[%0d]", k), {15'd0, imem_req}, 16'h0001);
    chk($sformatf("imem_addr[%0d]", k), imem_addr, exp_pc);
    for (int w = 0; w < v.ack_wait; w++) begin
      imem_ack = 1'b0;
      @(negedge clk);
      chk($sformatf("fetch_hold[%0d]", k), {13'd0, state}, 16'h0000);
    end
    imem_ack = 1'b1; imem_rdata = v.rdata;
    @(negedge clk);
    chk($sformatf("decode_state[%0d]", k), {13'd0, state}, 16'h0001);
    chk($sformatf("instr[%0d]", k), instr, v.rdata);
    chk($sformatf("op_code[%0d]", k), {12'd0, op_code}, {12'd0, v.rdata[15:12]});
    // Stray acks outside their phases must be ignored.
    imem_rdata = 16'hBEEF; dmem_ack = 1'b1;
    jump = v.jump; beq = v.beq; bne = v.bne; reg_write = v.reg_write;
    mem_op = v.mem_op; alu_zero = v.alu_zero;
    @(negedge clk);
    chk($sformatf("exec_state[%0d]", k), {13'd0, state}, 16'h0002);
    chk($sformatf("instr_hold[%0d]", k), instr, v.rdata);
    imem_ack = 1'b0; dmem_ack = 1'b0;
    if (v.path == P_BR) begin
      @(negedge clk);
    end else if (v.path == P_WB) begin
      @(negedge clk);
      chk($sformatf("wb_state[%0d]", k), {13'd0, state}, 16'h0004);
      chk($sformatf("wb_rwe[%0d]", k), {15'd0, reg_write_en}, {15'd0, v.reg_write});
      @(negedge clk);
    end else begin
      for (int i = 0; i <= v.dmem_wait; i++) begin
        @(negedge clk);
        chk($sformatf("mem_state[%0d]", k), {13'd0, state}, 16'h0003);
        if (mem_req) mem_cnt++;
        if (reg_write_en) rwe_seen++;
        dmem_ack = (i == v.dmem_wait);
      end
      @(negedge clk);
      dmem_ack = 1'b0;
      chk($sformatf("mem_req_cycles[%0d]", k), mem_cnt[15:0], v.dmem_wait[15:0] + 16'd1);
      if (v.path == P_LD) begin
        chk($sformatf("ld_wb_state[%0d]", k), {13'd0, state}, 16'h0004);
        chk($sformatf("ld_rwe[%0d]", k), {15'd0, reg_write_en}, {15'd0, v.reg_write});
        @(negedge clk);
      end else begin
        if (reg_write_en) rwe_seen++;
        chk($sformatf("st_rwe_seen[%0d]", k), rwe_seen[15:0], 16'h0000);
      end
    end
    exp_pc  = v.exp_pc;
    exp_ret = exp_ret + 16'd1;
    chk($sformatf("done_state[%0d]", k), {13'd0, state}, 16'h0000);
    chk($sformatf("pc[%0d]", k), pc, exp_pc);
    chk($sformatf("retired[%0d]", k), retired, exp_ret);
    clear_ctrl();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    //            rdata    aw jmp beq bne rw  mem    az dw path  exp_pc
    vecs[0]  = '{16'h0123, 0, N, N, N, Y, 2'b00, N, 0, P_WB, 16'h0001};
    vecs[1]  = '{16'h1234, 2, N, N, N, Y, 2'b01, N, 3, P_LD, 16'h0002};
    vecs[2]  = '{16'h2345, 1, N, N, N, N, 2'b10, N, 1, P_ST, 16'h0003};
    vecs[3]  = '{16'hF010, 0, Y, N, N, N, 2'b00, N, 0, P_BR, 16'h0010};
    vecs[4]  = '{16'h800E, 0, N, Y, N, N, 2'b00, Y, 0, P_BR, 16'h000F};
    vecs[5]  = '{16'hF010, 0, Y, N, N, N, 2'b00, N, 0, P_BR, 16'h0010};
    vecs[6]  = '{16'h800E, 0, N, Y, N, N, 2'b00, N, 0, P_BR, 16'h0011};
    vecs[7]  = '{16'hF010, 0, Y, N, N, N, 2'b00, N, 0, P_BR, 16'h0010};
    vecs[8]  = '{16'h900E, 0, N, N, Y, N, 2'b00, Y, 0, P_BR, 16'h0011};
    vecs[9]  = '{16'hF010, 0, Y, N, N, N, 2'b00, N, 0, P_BR, 16'h0010};
    vecs[10] = '{16'h900E, 0, N, N, Y, N, 2'b00, N, 0, P_BR, 16'h000F};
    vecs[11] = '{16'hF123, 0, Y, N, N, N, 2'b00, N, 0, P_BR, 16'h0123};
    vecs[12] = '{16'hF000, 0, Y, Y, N, Y, 2'b01, Y, 0, P_BR, 16'h0000};
    vecs[13] = '{16'h8008, 0, N, Y, N, N, 2'b00, Y, 0, P_BR, 16'hFFF9};
    vecs[14] = '{16'h5123, 0, Y, N, N, N, 2'b00, N, 0, P_BR, 16'hF123};
    vecs[15] = '{16'hBFFF, 0, Y, N, N, N, 2'b00, N, 0, P_BR, 16'hFFFF};
    vecs[16] = '{16'h3000, 0, N, N, N, N, 2'b11, N, 0, P_WB, 16'h0000};
    vecs[17] = '{16'h9007, 0, N, N, Y, N, 2'b00, N, 0, P_BR, 16'h0008};
    vecs[18] = '{16'h4444, 0, N, N, N, Y, 2'b01, N, 0, P_LD, 16'h0009};
    vecs[19] = '{16'h5555, 0, N, N, N, Y, 2'b10, N, 0, P_ST, 16'h000A};

    clear_ctrl();
    imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = 16'h0000;
    reset = 1'b1;
    // Reset held for several cycles: outputs stay at reset values.
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      chk("rst_state", {13'd0, state}, 16'h0000);
      chk("rst_pc", pc, 16'h0000);
      chk("rst_instr", instr, 16'h0000);
      chk("rst_retired", retired, 16'h0000);
      chk("rst_strobes", {13'd0, imem_req, mem_req, reg_write_en}, 16'h0004);
    end
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      run_vec(i, vecs[i]);
    end

    // Reset in the middle of a load's MEMORY wait; the late ack is ignored.
    imem_ack = 1'b1; imem_rdata = 16'h1111;
    @(negedge clk);
    imem_ack = 1'b0; mem_op = 2'b01; reg_write = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("mid_mem_state", {13'd0, state}, 16'h0003);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_mem_rst_state", {13'd0, state}, 16'h0000);
    chk("mid_mem_rst_pc", pc, 16'h0000);
    chk("mid_mem_rst_ret", retired, 16'h0000);
    reset = 1'b0; dmem_ack = 1'b1;
    @(negedge clk);
    chk("late_ack_state", {13'd0, state}, 16'h0000);
    chk("late_ack_mem_req", {15'd0, mem_req}, 16'h0000);
    dmem_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_pc", pc, 16'h0000);
    chk("late_ack_ret", retired, 16'h0000);
    chk("late_ack_rwe", {15'd0, reg_write_en}, 16'h0000);
    clear_ctrl();

    // Reset wins over an fetch ack in the same cycle.
    exp_pc = 16'h0000; exp_ret = 16'h0000;
    run_vec(100, vecs[0]);
    reset = 1'b1; imem_ack = 1'b1; imem_rdata = 16'h7777;
    @(negedge clk);
    chk("rst_vs_ack_state", {13'd0, state}, 16'h0000);
    chk("rst_vs_ack_instr", instr, 16'h0000);
    chk("rst_vs_ack_pc", pc, 16'h0000);
    chk("rst_vs_ack_ret", retired, 16'h0000);
    reset = 1'b0; imem_ack = 1'b0;
    @(negedge clk);
    chk("post_rst_state", {13'd0, state}, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
